side_buffer: RTL and testbench
==============================

Name: side_buffer

Overview:
- Small FIFO side buffer for the minimally-buffered deflection router.
- Sits directly downstream of the buffer-ejection stage. It captures the one 11-bit flit ejected per cycle from the N/S/E/W pipeline.
- Holds ejected flits and re-injects them into the router pipeline when a channel slot is free.
- Raises a forced-redirect request when the head flit starves, so the pipeline must make room for it.

Parameters:
- FLIT_W, 11, flit width; layout [10:9] type, [8:6] port code, [5:0] payload/address.
- DEPTH, 4, buffer entries; power of two, 2 to 16.
- CNT_W, 3, occupancy width; must equal log2(DEPTH)+1.
- STARVE_LIMIT, 8, consecutive cycles the head flit may wait before a forced redirect is requested; range 1 to 255.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- sbuff, input, FLIT_W, flit ejected by the upstream stage.
- sbuff_valid, input, 1, sbuff holds a real flit this cycle.
- buf_full, output, 1, no free entry; the upstream stage must not eject while this is high.
- buf_empty, output, 1, zero entries held.
- buf_count, output, CNT_W, current occupancy.
- inj_flit, output, FLIT_W, head flit offered for re-injection.
- inj_valid, output, 1, inj_flit is valid.
- inj_ready, input, 1, the pipeline has a free slot; the head flit is consumed when inj_valid and inj_ready are both high.
- force_redirect, output, 1, head flit has starved; the pipeline must free a slot.
- overflow, output, 1, sticky flag: a flit was dropped because the buffer was full.

Behaviour:
- All state changes on the rising edge of clk. Reset is synchronous: rst high at an edge overrides every other input.
- Reset values:
  - buf_count=0, buf_empty=1, buf_full=0.
  - inj_valid=0, inj_flit=0.
  - force_redirect=0, overflow=0, starve counter=0.
  - Pointers=0, state=IDLE.
- Stored flit contents are not cleared by reset; the data is don't-care while the buffer is empty.
- Push: sbuff_valid=1 and (not full, or a pop occurs in the same cycle). sbuff is written at the write pointer and the write pointer advances modulo DEPTH.
- Pop: inj_valid=1 and inj_ready=1. The read pointer advances modulo DEPTH.
- Push and pop in the same cycle: occupancy is unchanged. This is legal when full and when holding exactly one entry.
- Latency:
  - A flit pushed into an empty buffer appears on inj_flit with inj_valid=1 at the next cycle. There is no combinational fall-through.
  - Order is strict FIFO.
- inj_flit equals the memory entry at the read pointer whenever inj_valid=1. inj_valid equals not buf_empty.
- Overflow: sbuff_valid=1 while full with no pop means the flit is dropped, state is unchanged, and overflow is set. overflow clears only on rst.
- buf_full is high when buf_count==DEPTH. buf_empty is high when buf_count==0. Both are derived from registered state.
- Pointers wrap from DEPTH-1 to 0. The count uses the extra bit so that full and empty are distinguishable.
- Starvation FSM:
  - IDLE: buffer empty; counter=0. Goes to WAIT on the cycle after the buffer becomes non-empty.
  - WAIT: counter increments each cycle the head is offered and not popped.
    - On a pop, the counter resets to 0; the FSM stays in WAIT if entries remain, otherwise returns to IDLE.
    - When the counter reaches STARVE_LIMIT, go to FORCE.
  - FORCE: force_redirect=1 (registered, asserted in the state itself). The counter holds its value.
    - On a pop, force_redirect drops at the next edge, the counter resets to 0, and the FSM goes to WAIT or IDLE by remaining occupancy.
  - Each new head flit starts its own fresh starvation window.
- rst in mid-operation, including in FORCE or while full, returns to the reset values on that edge. The input and output of that cycle are ignored.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then sbuff_valid=0 for 5 cycles -> buf_empty=1, buf_count=0, inj_valid=0, force_redirect=0, overflow=0 throughout.
- Push 0x5A1 with inj_ready=0 -> one cycle later inj_valid=1, inj_flit=0x5A1, buf_count=1. Then set inj_ready=1 for one cycle -> buf_empty=1 at the next edge.
- Fill and wrap: push 0x001, 0x002, 0x003, 0x004 (DEPTH=4) -> buf_full=1, buf_count=4. Push 0x7FF with no pop -> dropped, overflow=1. Pop all -> order 0x001 to 0x004. Push 0x010 and 0x020 then pop both -> pointers have wrapped and the order is 0x010, 0x020.
- Simultaneous push and pop: with the buffer full, push 0x123 while popping -> buf_count stays 4, overflow stays 0, and 0x123 emerges 4th.
- Starvation: push one flit, hold inj_ready=0 -> force_redirect=1 exactly STARVE_LIMIT (8) cycles after inj_valid rises. Pulse inj_ready -> force_redirect=0 at the next edge and the FSM returns to IDLE.
- Reset mid-FORCE with 3 entries held -> after the rst edge, buf_count=0, force_redirect=0, inj_valid=0. A following push of 0x2AA emerges as the first flit out.

Source files
------------

// File: rtl/side_buffer.sv
// Side buffer for the deflection router: a small FIFO that holds ejected flits
// and re-injects them, with a starvation monitor that requests a forced redirect.
module side_buffer #(
    parameter int unsigned FLIT_W       = 11,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CNT_W        = 3,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] sbuff,
    input  logic              sbuff_valid,
    output logic              buf_full,
    output logic              buf_empty,
    output logic [CNT_W-1:0]  buf_count,
    output logic [FLIT_W-1:0] inj_flit,
    output logic              inj_valid,
    input  logic              inj_ready,
    output logic              force_redirect,
    output logic              overflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned STV_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_next;
    logic [PTR_W-1:0]  rd_next;
    logic [CNT_W-1:0]  count_next;
    logic [FLIT_W-1:0] head_next;
    logic [STV_W-1:0]  stv_cnt;
    logic [STV_W-1:0]  stv_inc;
    logic              push;
    logic              pop;
    logic              last_out;
    state_t            state;

    assign pop     = inj_valid & inj_ready;
    assign push    = sbuff_valid & (~buf_full | pop);
    assign stv_inc = stv_cnt + STV_W'(1);

    // Next-cycle pointers, occupancy and head word for the registered outputs.
    always_comb begin
        wr_next    = push ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_next    = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_next = buf_count + CNT_W'(push) - CNT_W'(pop);
        // The incoming flit becomes the head when nothing older remains.
        last_out   = buf_empty | (pop & (buf_count == CNT_W'(1)));
        head_next  = (push && last_out) ? sbuff : mem[rd_next];
    end

    // Storage is not reset; its contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= sbuff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
            buf_empty <= 1'b1;
            buf_full  <= 1'b0;
            inj_valid <= 1'b0;
            inj_flit  <= '0;
            overflow  <= 1'b0;
        end else begin
            wr_ptr    <= wr_next;
            rd_ptr    <= rd_next;
            buf_count <= count_next;
            buf_empty <= (count_next == '0);
            buf_full  <= (count_next == CNT_W'(DEPTH));
            inj_valid <= (count_next != '0);
            inj_flit  <= head_next;
            if (sbuff_valid && buf_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Starvation monitor: each head flit gets its own window of STARVE_LIMIT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            stv_cnt        <= '0;
            force_redirect <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_WAIT: begin
                    if (!buf_empty) begin
                        if (pop) begin
                            stv_cnt <= '0;
                            state   <= (count_next != '0) ? S_WAIT : S_IDLE;
                        end else if (stv_inc == STV_W'(STARVE_LIMIT)) begin
                            stv_cnt        <= stv_inc;
                            state          <= S_FORCE;
                            force_redirect <= 1'b1;
                        end else begin
                            stv_cnt <= stv_inc;
                            state   <= S_WAIT;
                        end
                    end
                end
                S_FORCE: begin
                    if (pop) begin
                        stv_cnt        <= '0;
                        force_redirect <= 1'b0;
                        state          <= (count_next != '0) ? S_WAIT : S_IDLE;
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    stv_cnt        <= '0;
                    force_redirect <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_side_buffer.sv
// Directed bench for side_buffer with a FIFO scoreboard and a starvation model.
module tb_side_buffer;

    localparam int unsigned FLIT_W       = 11;
    localparam int unsigned DEPTH        = 4;
    localparam int unsigned CNT_W        = 3;
    localparam int unsigned STARVE_LIMIT = 8;

    logic              clk;
    logic              rst;
    logic [FLIT_W-1:0] sbuff;
    logic              sbuff_valid;
    logic              buf_full;
    logic              buf_empty;
    logic [CNT_W-1:0]  buf_count;
    logic [FLIT_W-1:0] inj_flit;
    logic              inj_valid;
    logic              inj_ready;
    logic              force_redirect;
    logic              overflow;

    int checks   = 0;
    int failures = 0;

    logic [FLIT_W-1:0] q[$];
    int   exp_stv;
    logic exp_force;
    logic exp_ovf;

    side_buffer #(
        .FLIT_W(FLIT_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .sbuff(sbuff), .sbuff_valid(sbuff_valid),
        .buf_full(buf_full), .buf_empty(buf_empty), .buf_count(buf_count),
        .inj_flit(inj_flit), .inj_valid(inj_valid), .inj_ready(inj_ready),
        .force_redirect(force_redirect), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("buf_count", 32'(buf_count), 32'(q.size()));
        chk("buf_empty", 32'(buf_empty), 32'(q.size() == 0));
        chk("buf_full", 32'(buf_full), 32'(q.size() == DEPTH));
        chk("inj_valid", 32'(inj_valid), 32'(q.size() != 0));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("force_redirect", 32'(force_redirect), 32'(exp_force));
        if (q.size() != 0) chk("inj_flit", 32'(inj_flit), 32'(q[0]));
    endtask

    // One clock: drive inputs, check current outputs, advance the model, step the clock.
    task automatic cycle(input logic v, input logic [FLIT_W-1:0] f, input logic r);
        logic do_pop, do_push;
        sbuff_valid = v;
        sbuff       = f;
        inj_ready   = r;
        check_state();
        do_pop  = (q.size() != 0) && r;
        do_push = v && ((q.size() < DEPTH) || do_pop);
        if (v && !do_push) exp_ovf = 1'b1;
        if (q.size() != 0) begin
            if (do_pop) begin
                exp_stv   = 0;
                exp_force = 1'b0;
            end else if (!exp_force) begin
                exp_stv++;
                if (exp_stv == STARVE_LIMIT) exp_force = 1'b1;
            end
        end
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(f);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset for n cycles; when busy, the data inputs are active to show they are ignored.
    task automatic do_reset(input int n, input logic busy);
        rst         = 1'b1;
        sbuff_valid = busy;
        inj_ready   = busy;
        sbuff       = 11'h3FF;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst         = 1'b0;
        sbuff_valid = 1'b0;
        inj_ready   = 1'b0;
        q.delete();
        exp_stv   = 0;
        exp_force = 1'b0;
        exp_ovf   = 1'b0;
    endtask

    initial begin
        int n;
        clk = 1'b0;
        exp_stv = 0;
        exp_force = 1'b0;
        exp_ovf = 1'b0;

        // Reset then idle
        do_reset(2, 1'b0);
        chk("reset_inj_flit", 32'(inj_flit), 32'h0);
        repeat (5) cycle(1'b0, '0, 1'b0);

        // Single flit, one-cycle latency, then pop
        cycle(1'b1, 11'h5A1, 1'b0);
        chk("latency_flit", 32'(inj_flit), 32'h5A1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Fill, overflow drop, drain in order, wrap
        cycle(1'b1, 11'h001, 1'b0);
        cycle(1'b1, 11'h002, 1'b0);
        cycle(1'b1, 11'h003, 1'b0);
        cycle(1'b1, 11'h004, 1'b0);
        cycle(1'b1, 11'h7FF, 1'b0);
        chk("overflow_set", 32'(overflow), 32'h1);
        repeat (4) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 11'h010, 1'b0);
        cycle(1'b1, 11'h020, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Simultaneous push and pop while full and with one entry
        do_reset(1, 1'b0);
        cycle(1'b1, 11'h0A1, 1'b0);
        cycle(1'b1, 11'h0A2, 1'b0);
        cycle(1'b1, 11'h0A3, 1'b0);
        cycle(1'b1, 11'h0A4, 1'b0);
        cycle(1'b1, 11'h123, 1'b1);
        chk("full_pushpop_count", 32'(buf_count), 32'd4);
        chk("full_pushpop_ovf", 32'(overflow), 32'h0);
        repeat (3) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 11'h456, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Starvation latency and release
        cycle(1'b1, 11'h333, 1'b0);
        n = 0;
        while (!force_redirect && n < 20) begin
            cycle(1'b0, '0, 1'b0);
            n++;
        end
        chk("starve_latency", 32'(n), 32'(STARVE_LIMIT));
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        chk("force_release", 32'(force_redirect), 32'h0);
        repeat (2) cycle(1'b0, '0, 1'b0);

        // Reset mid-FORCE with three entries held
        cycle(1'b1, 11'h111, 1'b0);
        cycle(1'b1, 11'h222, 1'b0);
        cycle(1'b1, 11'h0EE, 1'b0);
        n = 0;
        while (!force_redirect && n < 20) begin
            cycle(1'b0, '0, 1'b0);
            n++;
        end
        chk("force_before_reset", 32'(force_redirect), 32'h1);
        chk("count_before_reset", 32'(buf_count), 32'd3);
        do_reset(1, 1'b1);
        chk("rst_count", 32'(buf_count), 32'h0);
        chk("rst_force", 32'(force_redirect), 32'h0);
        chk("rst_inj_valid", 32'(inj_valid), 32'h0);
        cycle(1'b1, 11'h2AA, 1'b0);
        chk("post_reset_head", 32'(inj_flit), 32'h2AA);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
